// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic compare-exchange stage.
//   is_pow2   : elaboration-time power-of-two test
//   pair_desc : direction of a pair given its lower index, block size and global direction
//   occ_t     : buffered-beat count (0..2)
package bitonic_pkg;

  typedef logic [1:0] occ_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // 1 = descending pair; blocks with the BLOCK bit set run opposite to the global direction
  function automatic logic pair_desc(input int idx, input int block, input logic desc);
    return logic'((idx & block) != 0) ^ desc;
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Single compare-exchange element.
//   a, b    : values at the lower / upper index of the pair
//   desc    : 0 = lower index receives the minimum, 1 = lower index receives the maximum
//   lo, hi  : values for the lower / upper index
//   swapped : 1 only when the two values were exchanged (never on equality)
module cmp_swap #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swapped
);

  logic a_lt_b;
  logic b_lt_a;

  // Strict compares so equal values never swap
  always_comb begin
    if (SIGNED) begin
      a_lt_b = $signed(a) < $signed(b);
      b_lt_a = $signed(b) < $signed(a);
    end else begin
      a_lt_b = a < b;
      b_lt_a = b < a;
    end
  end

  assign swapped = desc ? a_lt_b : b_lt_a;
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/bitonic_stage_pipe.sv
// One compare-exchange stage of a bitonic sorting network with a 2-entry output FIFO.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake; in_ready = buffer not full
//   in_desc             : global direction sampled with the beat (1 = descending)
//   in_data[0:INDEX-1]  : input elements
//   out_valid/out_ready : output handshake; out_valid = buffer not empty
//   out_data, out_swap  : head beat and its per-pair swap flags
//   occupancy           : buffered beats, 0..2
module bitonic_stage_pipe
  import bitonic_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned INDEX  = 8,
  parameter int unsigned BLOCK  = 8,
  parameter int unsigned DIST   = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_desc,
  input  logic [WIDTH-1:0]   in_data  [0:INDEX-1],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data [0:INDEX-1],
  output logic [INDEX/2-1:0] out_swap,
  output occ_t               occupancy
);

  localparam int unsigned NPAIR = INDEX / 2;

  // Parameter sanity checks
  if (!is_pow2(int'(INDEX)) || INDEX < 2 || !is_pow2(int'(BLOCK)) || BLOCK < 2 ||
      BLOCK > INDEX || !is_pow2(int'(DIST)) || DIST > BLOCK / 2) begin : g_bad_param
    $error("bitonic_stage_pipe: illegal INDEX/BLOCK/DIST combination");
  end

  logic [WIDTH-1:0] cmp_data [0:INDEX-1];
  logic [NPAIR-1:0] swap_c;

  // Pair p maps to the p-th index with the DIST bit clear, partnered with index+DIST
  for (genvar p = 0; p < int'(NPAIR); p++) begin : g_pair
    localparam int unsigned LO = (p / DIST) * 2 * DIST + (p % DIST);
    localparam int unsigned HI = LO + DIST;

    cmp_swap #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
    ) u_cs (
      .a       (in_data[LO]),
      .b       (in_data[HI]),
      .desc    (pair_desc(int'(LO), int'(BLOCK), in_desc)),
      .lo      (cmp_data[LO]),
      .hi      (cmp_data[HI]),
      .swapped (swap_c[p])
    );
  end

  logic [WIDTH-1:0] buf_data [2][0:INDEX-1];
  logic [NPAIR-1:0] buf_swap [2];
  logic             wr_ptr;
  logic             rd_ptr;
  occ_t             occ;
  logic             push;
  logic             pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // 2-entry FIFO: storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
      for (int e = 0; e < 2; e++) begin
        buf_swap[e] <= '0;
        for (int k = 0; k < int'(INDEX); k++) begin
          buf_data[e][k] <= '0;
        end
      end
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= cmp_data;
        buf_swap[wr_ptr] <= swap_c;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign out_data  = buf_data[rd_ptr];
  assign out_swap  = buf_swap[rd_ptr];
  assign occupancy = occ;

endmodule

// File: tb/tb_bitonic_stage_pipe.sv
// Bench for bitonic_stage_pipe: three parameterisations share one input stream and are
// checked every cycle against a queue-based reference model, plus literal expectations.
module tb_bitonic_stage_pipe;

  typedef struct packed {
    logic [63:0] d;   // element 0 in the most significant byte
    logic [3:0]  sw;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_desc = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data [0:7];

  logic       rdy0, rdy1, rdy2;
  logic       ov0, ov1, ov2;
  logic [7:0] od0 [0:7];
  logic [7:0] od1 [0:7];
  logic [7:0] od2 [0:7];
  logic [3:0] sw0, sw1, sw2;
  logic [1:0] oc0, oc1, oc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitonic_stage_pipe #(.WIDTH(8), .INDEX(8), .BLOCK(8), .DIST(4), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_desc(in_desc),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_swap(sw0), .occupancy(oc0));

  bitonic_stage_pipe #(.WIDTH(8), .INDEX(8), .BLOCK(4), .DIST(2), .SIGNED(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_desc(in_desc),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_swap(sw1), .occupancy(oc1));

  bitonic_stage_pipe #(.WIDTH(8), .INDEX(8), .BLOCK(8), .DIST(4), .SIGNED(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_desc(in_desc),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .out_swap(sw2), .occupancy(oc2));

  function automatic logic [63:0] pk(input logic [7:0] a [0:7]);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = a[i];
    return r;
  endfunction

  // Reference: walk all index pairs, order each by its direction
  function automatic beat_t model(input logic [7:0] din [0:7], input logic desc,
                                  input int blk, input int dst, input bit sgn);
    logic [7:0] o [0:7];
    beat_t r;
    int p = 0;
    o = din;
    r.sw = '0;
    for (int i = 0; i < 8; i++) begin
      if ((i & dst) == 0) begin
        int  j;
        int  va, vb;
        bit  up, sw;
        j  = i + dst;
        va = sgn ? int'($signed(din[i])) : int'(din[i]);
        vb = sgn ? int'($signed(din[j])) : int'(din[j]);
        up = (((i & blk) != 0) == bit'(desc));
        sw = up ? (va > vb) : (va < vb);
        if (sw) begin
          o[i] = din[j];
          o[j] = din[i];
        end
        r.sw[p] = sw;
        p++;
      end
    end
    r.d = pk(o);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference FIFO contents per instance
  beat_t q0[$];
  beat_t q1[$];
  beat_t q2[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      bit m_push, m_pop;
      m_push = (in_valid === 1'b1) && (q0.size() < 2);
      m_pop  = (q0.size() > 0) && (out_ready === 1'b1);
      if (m_pop) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        void'(q2.pop_front());
      end
      if (m_push) begin
        q0.push_back(model(in_data, in_desc, 8, 4, 1'b0));
        q1.push_back(model(in_data, in_desc, 4, 2, 1'b0));
        q2.push_back(model(in_data, in_desc, 8, 4, 1'b1));
      end
    end
  end

  task automatic cmp_one(input string nm, input int sz, input beat_t hd, input logic ov,
                         input logic rdy, input logic [1:0] oc, input logic [63:0] d,
                         input logic [3:0] sw);
    chk({nm, "_valid"}, 64'(ov), 64'(sz != 0));
    chk({nm, "_ready"}, 64'(rdy), 64'(sz != 2));
    chk({nm, "_occ"}, 64'(oc), 64'(sz));
    if (sz != 0) begin
      chk({nm, "_data"}, d, hd.d);
      chk({nm, "_swap"}, 64'(sw), 64'(hd.sw));
    end
  endtask

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    cmp_one("u0", q0.size(), (q0.size() != 0) ? q0[0] : '0, ov0, rdy0, oc0, pk(od0), sw0);
    cmp_one("u1", q1.size(), (q1.size() != 0) ? q1[0] : '0, ov1, rdy1, oc1, pk(od1), sw1);
    cmp_one("u2", q2.size(), (q2.size() != 0) ? q2[0] : '0, ov2, rdy2, oc2, pk(od2), sw2);
  end

  task automatic drive(input logic [7:0] d [0:7], input logic desc);
    in_data  = d;
    in_desc  = desc;
    in_valid = 1'b1;
  endtask

  task automatic one_beat(input logic [7:0] d [0:7], input logic desc);
    drive(d, desc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [7:0] tmp [0:7];
  logic [7:0] desc_in [0:7];
  int         k;
  logic       was_rdy;

  initial begin
    desc_in = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    in_data = '{default: 8'd0};

    // Reset state
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(ov0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_occ", 64'(oc0), 64'd0);
    chk("rst_data", pk(od0), 64'd0);
    chk("rst_swap", 64'(sw0), 64'd0);

    // Descending input, ascending stage: every pair swaps
    one_beat(desc_in, 1'b0);
    chk("asc_valid", 64'(ov0), 64'd1);
    chk("asc_data", pk(od0), 64'h03020100_07060504);
    chk("asc_swap", 64'(sw0), 64'hF);
    chk("asc_b4_data", pk(od1), 64'h05040706_03020100);
    chk("asc_b4_swap", 64'(sw1), 64'h3);

    // Same input, descending stage: nothing moves
    one_beat(desc_in, 1'b1);
    chk("dsc_data", pk(od0), 64'h07060504_03020100);
    chk("dsc_swap", 64'(sw0), 64'h0);

    // All equal: no swaps anywhere
    tmp = '{default: 8'd5};
    one_beat(tmp, 1'b0);
    chk("eq_swap0", 64'(sw0), 64'h0);
    chk("eq_swap1", 64'(sw1), 64'h0);
    chk("eq_data", pk(od0), 64'h05050505_05050505);

    // BLOCK=4, DIST=2: upper block descending
    tmp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
    one_beat(tmp, 1'b0);
    chk("b4_data", pk(od1), 64'h00010203_02030001);
    chk("b4_swap", 64'(sw1), 64'hC);

    // 0x80 vs 0x7F: unsigned swaps, signed does not
    tmp = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00};
    one_beat(tmp, 1'b0);
    chk("uns_data", pk(od0), 64'h7F000000_80000000);
    chk("uns_swap", 64'(sw0), 64'h1);
    chk("sgn_data", pk(od2), 64'h80000000_7F000000);
    chk("sgn_swap", 64'(sw2), 64'h0);
    @(negedge clk);

    // Backpressure: two beats accepted, then stalled
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 8; i++) tmp[i] = 8'(k * 37 + i * 91 + 13);
      drive(tmp, k[0]);
      was_rdy = rdy0;
      @(negedge clk);
      if (was_rdy) k++;
    end
    chk("bp_accepted", 64'(k), 64'd2);
    chk("bp_occ", 64'(oc0), 64'd2);
    chk("bp_ready", 64'(rdy0), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain1_occ", 64'(oc0), 64'd1);
    @(negedge clk);
    chk("drain2_occ", 64'(oc0), 64'd0);

    // Streaming at full rate
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 8; i++) tmp[i] = 8'(c * 53 + i * 29 + 200);
      drive(tmp, 1'(c >> 1));
      @(negedge clk);
      chk("stream_occ", 64'(oc0), 64'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Async reset while full
    out_ready = 1'b0;
    drive(desc_in, 1'b0);
    @(negedge clk);
    drive(tmp, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_occ", 64'(oc0), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov0), 64'd0);
    chk("arst_occ", 64'(oc0), 64'd0);
    chk("arst_ready", 64'(rdy0), 64'd1);
    chk("arst_data", pk(od0), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(ov0), 64'd0);
    one_beat(desc_in, 1'b0);
    chk("post_rst_lat", 64'(ov0), 64'd1);
    chk("post_rst_data", pk(od0), 64'h03020100_07060504);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
